// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the request arbiters
//
// Purpose: state encoding, requester count, grant-code width and the
// round-robin pointer reset value shared by priority_arbiter_8 and the
// rotating_priority_pick helper.
// Ports: none (package).

package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int CODE_W  = 3;

  // Pointer value after reset: the round-robin scan then starts at index 0.
  localparam logic [CODE_W-1:0] RR_PTR_RESET = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arbState_t;

endpackage

// File: rtl/rotating_priority_pick.sv
// rtl/rotating_priority_pick.sv - combinational fixed/round-robin winner pick
//
// Purpose: picks one requester from reqIn.
//   modeRr=0: highest set index wins.
//   modeRr=1: scan rrPtr+1, rrPtr+2, ... modulo NUM_REQ; first set bit wins.
// Ports:
//   reqIn  [NUM_REQ-1:0] in  request vector
//   rrPtr  [CODE_W-1:0]  in  index of the previous round-robin winner
//   modeRr               in  0 = fixed priority, 1 = round-robin
//   winner [CODE_W-1:0]  out index of the chosen requester (0 when none)
//   anyReq               out at least one request is present

module rotating_priority_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] reqIn,
  input  logic [CODE_W-1:0]  rrPtr,
  input  logic               modeRr,
  output logic [CODE_W-1:0]  winner,
  output logic               anyReq
);

  logic [CODE_W-1:0]  shift;
  logic [NUM_REQ-1:0] rotated;
  logic [CODE_W-1:0]  pickIdx;

  // Rotating by rrPtr+1 puts the first index of the round-robin scan at bit 0.
  // The 3-bit add wraps naturally modulo NUM_REQ.
  assign shift  = modeRr ? rrPtr + CODE_W'(1) : '0;
  assign anyReq = |reqIn;

  always_comb begin
    rotated = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rotated[i] = reqIn[CODE_W'(i) + shift];
    end
  end

  // Round-robin wants the lowest rotated index, fixed priority the highest.
  // Each loop lets the preferred bit overwrite the others by visiting it last.
  always_comb begin
    pickIdx = '0;
    if (modeRr) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (rotated[i]) pickIdx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rotated[i]) pickIdx = CODE_W'(i);
      end
    end
  end

  assign winner = pickIdx + shift;

endmodule

// File: rtl/priority_arbiter_8.sv
// rtl/priority_arbiter_8.sv - 8-requester fixed/round-robin arbiter with hold timeout
//
// Purpose: grants one of eight requesters, holds the grant while the winner
// keeps requesting (up to MAX_HOLD cycles, 0 = unlimited), and inserts one
// idle turnaround cycle after every grant. All outputs are registered.
// Ports:
//   clk                    in  rising-edge clock
//   resetN                 in  asynchronous active-low reset
//   reqIn        [7:0]     in  request vector, bit i = requester i
//   modeRr                 in  0 = fixed priority (bit 7 highest), 1 = round-robin
//   grantOut     [7:0]     out one-hot grant, zero when idle
//   grantCode    [2:0]     out binary index of the grant, 0 when idle
//   grantValid             out a grant is active
//   timeoutPulse           out one-cycle pulse when a grant is revoked by MAX_HOLD

module priority_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [NUM_REQ-1:0] reqIn,
  input  logic               modeRr,
  output logic [NUM_REQ-1:0] grantOut,
  output logic [CODE_W-1:0]  grantCode,
  output logic               grantValid,
  output logic               timeoutPulse
);

  arbState_t          state, stateNext;
  logic [CNT_W-1:0]   holdCnt, holdCntNext;
  logic [CODE_W-1:0]  rrPtr, rrPtrNext;
  logic [NUM_REQ-1:0] grantOutNext;
  logic [CODE_W-1:0]  grantCodeNext;
  logic               grantValidNext;
  logic               timeoutNext;
  logic [CODE_W-1:0]  winner;
  logic               anyReq;

  rotating_priority_pick uPick (
    .reqIn  (reqIn),
    .rrPtr  (rrPtr),
    .modeRr (modeRr),
    .winner (winner),
    .anyReq (anyReq)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      holdCnt      <= '0;
      rrPtr        <= RR_PTR_RESET;
      grantOut     <= '0;
      grantCode    <= '0;
      grantValid   <= 1'b0;
      timeoutPulse <= 1'b0;
    end else begin
      state        <= stateNext;
      holdCnt      <= holdCntNext;
      rrPtr        <= rrPtrNext;
      grantOut     <= grantOutNext;
      grantCode    <= grantCodeNext;
      grantValid   <= grantValidNext;
      timeoutPulse <= timeoutNext;
    end
  end

  always_comb begin
    stateNext      = state;
    holdCntNext    = holdCnt;
    rrPtrNext      = rrPtr;
    grantOutNext   = grantOut;
    grantCodeNext  = grantCode;
    grantValidNext = grantValid;
    timeoutNext    = 1'b0;

    unique case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext      = GRANT;
          grantOutNext   = NUM_REQ'(1) << winner;
          grantCodeNext  = winner;
          grantValidNext = 1'b1;
          holdCntNext    = '0;
          rrPtrNext      = winner;
        end
      end
      GRANT: begin
        // Release is checked first so a simultaneous release and timeout
        // never raises timeoutPulse. Other requesters cannot preempt.
        if (!reqIn[grantCode]) begin
          stateNext      = GAP;
          grantOutNext   = '0;
          grantCodeNext  = '0;
          grantValidNext = 1'b0;
          holdCntNext    = '0;
        end else if (MAX_HOLD != 0 && holdCnt == CNT_W'(MAX_HOLD - 1)) begin
          stateNext      = GAP;
          grantOutNext   = '0;
          grantCodeNext  = '0;
          grantValidNext = 1'b0;
          holdCntNext    = '0;
          timeoutNext    = 1'b1;
        end else begin
          holdCntNext = holdCnt + CNT_W'(1);
        end
      end
      GAP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_priority_arbiter_8.sv
// tb/tb_priority_arbiter_8.sv - self-checking bench for priority_arbiter_8

module tb_priority_arbiter_8;

  typedef struct {
    logic [7:0] gOut;
    logic [2:0] code;
    logic       valid;
    logic       timeout;
  } exp_t;

  typedef struct {
    logic [7:0] req;
    logic       mode;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] reqIn = 8'h00;
  logic       modeRr = 1'b0;
  logic [7:0] grantOut;
  logic [2:0] grantCode;
  logic       grantValid;
  logic       timeoutPulse;

  int vectors = 0;
  int miscompares = 0;

  exp_t expQ[$];
  vec_t tbl[17];

  // Reference model state: 0 = idle, 1 = grant, 2 = gap
  int         mState;
  logic [2:0] mCode;
  logic [2:0] mPtr;
  int         mHold;

  priority_arbiter_8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .reqIn        (reqIn),
    .modeRr       (modeRr),
    .grantOut     (grantOut),
    .grantCode    (grantCode),
    .grantValid   (grantValid),
    .timeoutPulse (timeoutPulse)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] pickRef(input logic [7:0] r, input logic m, input logic [2:0] p);
    logic [2:0] w;
    int idx;
    w = 3'd0;
    if (!m) begin
      for (int i = 0; i < 8; i++) if (r[i]) w = 3'(i);
    end else begin
      for (int k = 8; k >= 1; k--) begin
        idx = (int'(p) + k) % 8;
        if (r[idx]) w = 3'(idx);
      end
    end
    return w;
  endfunction

  task automatic modelReset();
    mState = 0;
    mCode  = 3'd0;
    mPtr   = 3'd7;
    mHold  = 0;
  endtask

  task automatic modelStep(input logic [7:0] r, input logic m, output exp_t e);
    e.timeout = 1'b0;
    case (mState)
      0: if (r != 8'h00) begin
        mCode  = pickRef(r, m, mPtr);
        mPtr   = mCode;
        mHold  = 0;
        mState = 1;
      end
      1: begin
        if (!r[mCode]) mState = 2;
        else if (mHold == 15) begin
          mState = 2;
          e.timeout = 1'b1;
        end else mHold++;
      end
      default: mState = 0;
    endcase
    e.valid = (mState == 1);
    e.code  = e.valid ? mCode : 3'd0;
    e.gOut  = e.valid ? (8'h01 << mCode) : 8'h00;
  endtask

  task automatic checkOut(input string tag);
    exp_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = expQ.pop_front();
    if (grantOut !== e.gOut || grantCode !== e.code || grantValid !== e.valid || timeoutPulse !== e.timeout) begin
      miscompares++;
      $display("FAIL %s: got out=%b code=%0d valid=%b to=%b, want out=%b code=%0d valid=%b to=%b",
               tag, grantOut, grantCode, grantValid, timeoutPulse, e.gOut, e.code, e.valid, e.timeout);
    end
  endtask

  task automatic checkVal(input string tag, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, act, want);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic m, input string tag);
    exp_t e;
    reqIn  = r;
    modeRr = m;
    modelStep(r, m, e);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOut(tag);
  endtask

  task automatic pushZero();
    exp_t e;
    e.gOut = 8'h00; e.code = 3'd0; e.valid = 1'b0; e.timeout = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic doReset(input string tag);
    reqIn  = 8'h00;
    modeRr = 1'b0;
    resetN = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    pushZero();
    checkOut(tag);
    resetN = 1'b1;
  endtask

  task automatic setVec(input int i, input logic [7:0] r, input logic m,
                        input logic [7:0] go, input logic [2:0] c, input logic v, input logic t);
    tbl[i].req = r; tbl[i].mode = m;
    tbl[i].e.gOut = go; tbl[i].e.code = c; tbl[i].e.valid = v; tbl[i].e.timeout = t;
  endtask

  initial begin
    exp_t dummy;
    int grants, prevValid, c0, ct, c2, sawTo, dropSeen;
    logic [7:0] r;
    logic [2:0] order[9];

    // Hand-computed vectors, starting from reset (rrPtr = 7).
    setVec(0,  8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    setVec(1,  8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    setVec(2,  8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    setVec(3,  8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    setVec(4,  8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    setVec(5,  8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    setVec(6,  8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    setVec(7,  8'h0C, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0);
    setVec(8,  8'h0C, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    setVec(9,  8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    setVec(10, 8'h0C, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    setVec(11, 8'h0C, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    setVec(12, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    setVec(13, 8'h0C, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    setVec(14, 8'h0C, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);
    setVec(15, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    setVec(16, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    modelReset();
    #2;
    doReset("reset_state");

    for (int i = 0; i < 17; i++) begin
      reqIn  = tbl[i].req;
      modeRr = tbl[i].mode;
      modelStep(tbl[i].req, tbl[i].mode, dummy);
      expQ.push_back(tbl[i].e);
      @(posedge clk);
      #1;
      checkOut($sformatf("table[%0d]", i));
    end

    // Round-robin, all requesting, each winner drops for one cycle after 3 grant cycles.
    doReset("reset_rr");
    grants = 0;
    prevValid = 0;
    for (int cyc = 0; cyc < 60 && grants < 9; cyc++) begin
      r = 8'hFF;
      if (mState == 1 && mHold == 2) r[mCode] = 1'b0;
      step(r, 1'b1, "rr_seq");
      if (grantValid && !prevValid) begin
        order[grants] = grantCode;
        grants++;
      end
      prevValid = int'(grantValid);
    end
    checkVal("rr_grant_count", grants, 9);
    for (int i = 0; i < 9; i++) checkVal($sformatf("rr_order[%0d]", i), int'(order[i]), i % 8);

    // Timeout: requester 7 held continuously.
    doReset("reset_to");
    c0 = -1; ct = -1; c2 = -1;
    for (int cyc = 1; cyc <= 40 && c2 < 0; cyc++) begin
      step(8'h80, 1'b0, "to_seq");
      if (grantValid && c0 < 0) c0 = cyc;
      if (timeoutPulse && ct < 0) ct = cyc;
      if (ct >= 0 && cyc > ct && grantValid && c2 < 0) c2 = cyc;
    end
    checkVal("to_hold_len", ct - c0, 16);
    checkVal("to_regrant_gap", c2 - ct, 2);
    checkVal("to_regrant_code", int'(grantCode), 7);

    // Release on the exact cycle the hold counter reaches its limit.
    sawTo = 0;
    dropSeen = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      r = 8'h80;
      if (mState == 1 && mHold == 15) begin
        r = 8'h00;
        dropSeen++;
      end
      step(r, 1'b0, "rel_at_limit");
      if (timeoutPulse) sawTo++;
    end
    checkVal("rel_at_limit_drop", dropSeen, 1);
    checkVal("rel_at_limit_no_to", sawTo, 0);

    // Asynchronous reset in the middle of a grant.
    doReset("reset_async");
    step(8'h08, 1'b0, "async_grant");
    step(8'h08, 1'b0, "async_hold");
    #2;
    resetN = 1'b0;
    #1;
    modelReset();
    pushZero();
    checkOut("async_rst_immediate");
    #2;
    resetN = 1'b1;
    step(8'h0C, 1'b1, "async_rr_after");
    checkVal("async_rr_code", int'(grantCode), 2);

    // Random traffic; requests tend to persist so holds and timeouts occur.
    doReset("reset_rand");
    r = 8'h00;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
      step(r, 1'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
